// File: rtl/cve2_hpm_counters_if.sv
// CSR access port of the machine counter block: address decode, write strobe and read data.
interface cve2_hpm_counters_if;
  // No ready: csr_we_i is a one-cycle strobe, the write always lands on the next edge.
  // csr_rdata_o and csr_hit_o are combinational in csr_addr_i.
  logic [11:0] csr_addr_i;
  logic        csr_we_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  modport master (
    output csr_addr_i, csr_we_i, csr_wdata_i,
    input  csr_rdata_o, csr_hit_o
  );

  modport slave (
    input  csr_addr_i, csr_we_i, csr_wdata_i,
    output csr_rdata_o, csr_hit_o
  );
endinterface

// File: rtl/cve2_hpm_counters.sv
// Machine counters (mcycle, minstret, mhpmcounter3..) with mhpmevent selectors and mcountinhibit.
// Define CVE2_HPM_OVERFLOW_EN to add sticky per-mhpmcounter wrap flags on counter_ovf_o.
module cve2_hpm_counters #(
  parameter int MHPMCounterNum   = 10,
  parameter int MHPMCounterWidth = 40,
  parameter int NumEvents        = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  cve2_hpm_counters_if.slave        csr,
  input  logic                      instr_ret_i,
  input  logic [NumEvents-1:0]      event_i,
  input  logic                      counter_stop_i,
  output logic [MHPMCounterNum-1:0] counter_ovf_o
);

  localparam int NCnt = (MHPMCounterNum > 0) ? MHPMCounterNum : 1;
  // Writable inhibit bits: mcycle, minstret and the implemented mhpmcounters.
  localparam logic [31:0] InhMask =
    32'h5 | (32'((64'd1 << MHPMCounterNum) - 64'd1) << 3);
  localparam logic [6:0] RegCfg = 7'h19;  // 0x320-0x33F
  localparam logic [6:0] RegLo  = 7'h58;  // 0xB00-0xB1F
  localparam logic [6:0] RegHi  = 7'h5C;  // 0xB80-0xB9F

  logic [4:0]  csr_idx;
  logic        sel_cfg, sel_lo, sel_hi;
  logic        wr_cfg, wr_lo, wr_hi;

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [31:0] mcountinhibit_q, mcountinhibit_d;
  logic [MHPMCounterWidth-1:0] hpm_q [NCnt];
  logic [MHPMCounterWidth-1:0] hpm_d [NCnt];
  logic [NumEvents-1:0]        mhpmevent_q [NCnt];
  logic [NumEvents-1:0]        mhpmevent_d [NCnt];
  logic [NCnt-1:0]             hpm_wr_lo, hpm_wr_hi, hpm_inc;

  assign csr_idx       = csr.csr_addr_i[4:0];
  assign sel_cfg       = (csr.csr_addr_i[11:5] == RegCfg);
  assign sel_lo        = (csr.csr_addr_i[11:5] == RegLo);
  assign sel_hi        = (csr.csr_addr_i[11:5] == RegHi);
  assign wr_cfg        = csr.csr_we_i && sel_cfg;
  assign wr_lo         = csr.csr_we_i && sel_lo;
  assign wr_hi         = csr.csr_we_i && sel_hi;
  assign csr.csr_hit_o = sel_cfg || sel_lo || sel_hi;

  always_comb begin
    hpm_wr_lo = '0;
    hpm_wr_hi = '0;
    hpm_inc   = '0;
    for (int j = 0; j < MHPMCounterNum; j++) begin
      hpm_wr_lo[j] = wr_lo && (csr_idx == 5'(j + 3));
      hpm_wr_hi[j] = wr_hi && (csr_idx == 5'(j + 3));
      hpm_inc[j]   = (|(mhpmevent_q[j] & event_i)) && !mcountinhibit_q[j + 3] && !counter_stop_i;
    end
  end

  // A write to either half takes priority over that counter's increment.
  always_comb begin
    mcycle_d = mcycle_q;
    if (wr_lo && csr_idx == 5'd0)      mcycle_d[31:0]  = csr.csr_wdata_i;
    else if (wr_hi && csr_idx == 5'd0) mcycle_d[63:32] = csr.csr_wdata_i;
    else if (!mcountinhibit_q[0] && !counter_stop_i) mcycle_d = mcycle_q + 64'd1;

    minstret_d = minstret_q;
    if (wr_lo && csr_idx == 5'd2)      minstret_d[31:0]  = csr.csr_wdata_i;
    else if (wr_hi && csr_idx == 5'd2) minstret_d[63:32] = csr.csr_wdata_i;
    else if (instr_ret_i && !mcountinhibit_q[2] && !counter_stop_i) minstret_d = minstret_q + 64'd1;
  end

  always_comb begin
    logic [63:0] cur;
    cur = '0;
    for (int j = 0; j < NCnt; j++) begin
      cur = 64'(hpm_q[j]);
      if (hpm_wr_lo[j])      cur[31:0]  = csr.csr_wdata_i;
      else if (hpm_wr_hi[j]) cur[63:32] = csr.csr_wdata_i;
      else if (hpm_inc[j])   cur        = cur + 64'd1;
      hpm_d[j] = MHPMCounterWidth'(cur);
    end
  end

  always_comb begin
    mcountinhibit_d = mcountinhibit_q;
    if (wr_cfg && csr_idx == 5'd0) mcountinhibit_d = csr.csr_wdata_i & InhMask;
    for (int j = 0; j < NCnt; j++) begin
      mhpmevent_d[j] = mhpmevent_q[j];
      if (j < MHPMCounterNum && wr_cfg && csr_idx == 5'(j + 3))
        mhpmevent_d[j] = NumEvents'(csr.csr_wdata_i);
    end
  end

  always_comb begin
    logic [63:0] rd64;
    rd64            = '0;
    csr.csr_rdata_o = '0;
    if (sel_cfg) begin
      if (csr_idx == 5'd0) csr.csr_rdata_o = mcountinhibit_q;
      for (int j = 0; j < MHPMCounterNum; j++)
        if (csr_idx == 5'(j + 3)) csr.csr_rdata_o = 32'(mhpmevent_q[j]);
    end else begin
      if (csr_idx == 5'd0)      rd64 = mcycle_q;
      else if (csr_idx == 5'd2) rd64 = minstret_q;
      for (int j = 0; j < MHPMCounterNum; j++)
        if (csr_idx == 5'(j + 3)) rd64 = 64'(hpm_q[j]);
      if (sel_lo)      csr.csr_rdata_o = rd64[31:0];
      else if (sel_hi) csr.csr_rdata_o = rd64[63:32];
    end
    if (rst_i) csr.csr_rdata_o = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q        <= '0;
      minstret_q      <= '0;
      mcountinhibit_q <= '0;
      for (int j = 0; j < NCnt; j++) begin
        hpm_q[j]       <= '0;
        mhpmevent_q[j] <= '0;
      end
    end else begin
      mcycle_q        <= mcycle_d;
      minstret_q      <= minstret_d;
      mcountinhibit_q <= mcountinhibit_d;
      for (int j = 0; j < NCnt; j++) begin
        hpm_q[j]       <= hpm_d[j];
        mhpmevent_q[j] <= mhpmevent_d[j];
      end
    end
  end

`ifdef CVE2_HPM_OVERFLOW_EN
  logic [MHPMCounterNum-1:0] ovf_q, ovf_d;

  // A write to the counter clears its flag even if the counter would wrap that cycle.
  always_comb begin
    ovf_d = ovf_q;
    for (int j = 0; j < MHPMCounterNum; j++) begin
      if (hpm_wr_lo[j] || hpm_wr_hi[j])        ovf_d[j] = 1'b0;
      else if (hpm_inc[j] && (&hpm_q[j]))      ovf_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign counter_ovf_o = ovf_q;
`else
  assign counter_ovf_o = '0;
`endif

endmodule

// File: tb/tb_cve2_hpm_counters.sv
// Bench for cve2_hpm_counters: counter-array reference model checked every cycle, plus literal checks.
module tb_cve2_hpm_counters;
  localparam int N = 10;
  localparam int W = 40;
  localparam int E = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_ret;
  logic [E-1:0] event_v;
  logic         stop;
  logic [N-1:0] ovf;

  int n_checks = 0;
  int n_errors = 0;

  cve2_hpm_counters_if bus();

  cve2_hpm_counters #(
    .MHPMCounterNum(N), .MHPMCounterWidth(W), .NumEvents(E)
  ) dut (
    .clk_i(clk), .rst_i(rst), .csr(bus), .instr_ret_i(instr_ret),
    .event_i(event_v), .counter_stop_i(stop), .counter_ovf_o(ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model: counters indexed by CSR number ----------------
  longint unsigned m_cnt [32];
  logic [31:0]     m_inh;
  logic [31:0]     m_evt [32];
`ifdef CVE2_HPM_OVERFLOW_EN
  logic [N-1:0]    m_ovf;
`endif

  function automatic bit is_counter(int k);
    return (k == 0) || (k == 2) || (k >= 3 && k < 3 + N);
  endfunction

  function automatic longint unsigned width_mask(int k);
    if (k < 3 || W == 64) return '1;
    return (64'd1 << W) - 64'd1;
  endfunction

  task automatic model_step();
    longint unsigned nxt [32];
    logic [6:0] region;
    int idx;
    bit lo_w, hi_w, inc;
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        m_cnt[k] = 0;
        m_evt[k] = '0;
      end
      m_inh = '0;
`ifdef CVE2_HPM_OVERFLOW_EN
      m_ovf = '0;
`endif
      return;
    end
    region = bus.csr_addr_i[11:5];
    idx    = int'(bus.csr_addr_i[4:0]);
    for (int k = 0; k < 32; k++) begin
      nxt[k] = m_cnt[k];
      if (!is_counter(k)) continue;
      lo_w = bus.csr_we_i && region == 7'h58 && idx == k;
      hi_w = bus.csr_we_i && region == 7'h5C && idx == k;
      if (k == 0)      inc = 1'b1;
      else if (k == 2) inc = instr_ret;
      else             inc = (m_evt[k] & 32'(event_v)) != 0;
      inc = inc && !m_inh[k] && !stop;
      if (lo_w)
        nxt[k] = (((m_cnt[k] >> 32) << 32) | 64'(bus.csr_wdata_i)) & width_mask(k);
      else if (hi_w)
        nxt[k] = ((m_cnt[k] & 64'hFFFF_FFFF) | (64'(bus.csr_wdata_i) << 32)) & width_mask(k);
      else if (inc) begin
        nxt[k] = (m_cnt[k] + 1) & width_mask(k);
`ifdef CVE2_HPM_OVERFLOW_EN
        if (k >= 3 && nxt[k] == 0) m_ovf[k - 3] = 1'b1;
`endif
      end
`ifdef CVE2_HPM_OVERFLOW_EN
      if (k >= 3 && (lo_w || hi_w)) m_ovf[k - 3] = 1'b0;
`endif
    end
    if (bus.csr_we_i && region == 7'h19) begin
      if (idx == 0)
        for (int k = 0; k < 32; k++) m_inh[k] = bus.csr_wdata_i[k] && is_counter(k);
      else if (idx >= 3 && idx < 3 + N)
        for (int k = 0; k < 32; k++) m_evt[idx][k] = bus.csr_wdata_i[k] && (k < E);
    end
    for (int k = 0; k < 32; k++) m_cnt[k] = nxt[k];
  endtask

  function automatic void model_read(input logic [11:0] a, output logic hit, output logic [31:0] d);
    logic [6:0] region;
    int k;
    region = a[11:5];
    k      = int'(a[4:0]);
    hit    = (region == 7'h19) || (region == 7'h58) || (region == 7'h5C);
    d      = '0;
    if (rst) d = '0;
    else if (region == 7'h19) begin
      if (k == 0) d = m_inh;
      else if (k >= 3 && k < 3 + N) d = m_evt[k];
    end else if (region == 7'h58 && is_counter(k)) d = m_cnt[k][31:0];
    else if (region == 7'h5C && is_counter(k))     d = m_cnt[k][63:32];
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  initial forever begin
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [N-1:0] exp_ovf;
    @(negedge clk);
    model_read(bus.csr_addr_i, exp_hit, exp_data);
`ifdef CVE2_HPM_OVERFLOW_EN
    exp_ovf = m_ovf;
`else
    exp_ovf = '0;
`endif
    check($sformatf("rdata@%03h", bus.csr_addr_i), 64'(bus.csr_rdata_o), 64'(exp_data));
    check($sformatf("hit@%03h", bus.csr_addr_i), 64'(bus.csr_hit_o), 64'(exp_hit));
    check("ovf", 64'(ovf), 64'(exp_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = d;
    bus.csr_we_i    = 1'b1;
    tick();
    bus.csr_we_i    = 1'b0;
  endtask

  task automatic expect_rd(input logic [11:0] a, input logic [31:0] d, input logic h, input string name);
    bus.csr_addr_i = a;
    #1;
    check(name, 64'(bus.csr_rdata_o), 64'(d));
    check({name, "_hit"}, 64'(bus.csr_hit_o), 64'(h));
  endtask

  task automatic pulse_event(input logic [E-1:0] ev);
    event_v = ev;
    tick();
    event_v = '0;
  endtask

  // ---------------- directed stimulus ----------------
  localparam int NPAT = 8;
  logic [E-1:0] pat_ev [NPAT] = '{16'h0001, 16'h0002, 16'h0004, 16'h8000,
                                  16'h8006, 16'h0000, 16'hFFFF, 16'h0010};
  logic [11:0]  pat_rd [NPAT] = '{12'hB00, 12'hB80, 12'hB02, 12'hB03,
                                  12'hB04, 12'hB0C, 12'h324, 12'h320};

  initial begin
    rst = 1'b1;
    instr_ret = 1'b0;
    event_v = '0;
    stop = 1'b0;
    bus.csr_addr_i = '0;
    bus.csr_we_i = 1'b0;
    bus.csr_wdata_i = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Free-running mcycle after reset
    bus.csr_addr_i = 12'hB00;
    repeat (5) tick();
    expect_rd(12'hB00, 32'd5, 1'b1, "mcycle_lo_after5");
    expect_rd(12'hB80, 32'd0, 1'b1, "mcycle_hi_after5");
    expect_rd(12'hB02, 32'd0, 1'b1, "minstret_idle");

    // Low-half carry into high half
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    expect_rd(12'hB00, 32'h0, 1'b1, "mcycle_lo_carry");
    expect_rd(12'hB80, 32'h1, 1'b1, "mcycle_hi_carry");

    // 40-bit mhpmcounter3 wrap
    wr(12'h323, 32'h1);
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    expect_rd(12'hB83, 32'h0000_00FF, 1'b1, "hpm3_hi_truncated");
    pulse_event(16'h0001);
    expect_rd(12'hB03, 32'h0, 1'b1, "hpm3_lo_wrap");
    expect_rd(12'hB83, 32'h0, 1'b1, "hpm3_hi_wrap");
`ifdef CVE2_HPM_OVERFLOW_EN
    check("ovf0_set", 64'(ovf[0]), 64'd1);
`endif

    // Inhibit mhpmcounter3, then release
    wr(12'h320, 32'h8);
    pulse_event(16'h0001);
    expect_rd(12'hB03, 32'h0, 1'b1, "hpm3_inhibited");
    wr(12'h320, 32'h0);
    pulse_event(16'h0001);
    expect_rd(12'hB03, 32'h1, 1'b1, "hpm3_released");
`ifdef CVE2_HPM_OVERFLOW_EN
    check("ovf0_sticky", 64'(ovf[0]), 64'd1);
`endif

    // Write beats a same-cycle increment
    event_v = 16'h0001;
    wr(12'hB03, 32'd7);
    event_v = '0;
    expect_rd(12'hB03, 32'd7, 1'b1, "hpm3_write_wins");
`ifdef CVE2_HPM_OVERFLOW_EN
    check("ovf0_cleared", 64'(ovf[0]), 64'd0);
`endif

    // Stopcount freezes minstret
    stop = 1'b1;
    instr_ret = 1'b1;
    tick();
    stop = 1'b0;
    expect_rd(12'hB02, 32'd0, 1'b1, "minstret_stopped");
    tick();
    instr_ret = 1'b0;
    expect_rd(12'hB02, 32'd1, 1'b1, "minstret_one");

    // Several event patterns over three counters; entry 6 is stopped
    wr(12'h324, 32'h6);
    wr(12'h32C, 32'h8000);
    for (int i = 0; i < NPAT; i++) begin
      event_v = pat_ev[i];
      stop = (i == 6);
      instr_ret = 1'b1;
      bus.csr_addr_i = pat_rd[i];
      tick();
    end
    event_v = '0;
    stop = 1'b0;
    instr_ret = 1'b0;
    expect_rd(12'hB04, 32'd3, 1'b1, "hpm4_count");
    expect_rd(12'hB0C, 32'd2, 1'b1, "hpm12_count");
    expect_rd(12'hB02, 32'd8, 1'b1, "minstret_count");
    tick();
    expect_rd(12'hB03, 32'd8, 1'b1, "hpm3_count");

    // Unimplemented and foreign addresses, WARL masks
    tick();
    expect_rd(12'hB81, 32'h0, 1'b1, "time_hi");
    expect_rd(12'h33F, 32'h0, 1'b1, "mhpmevent31");
    expect_rd(12'h300, 32'h0, 1'b0, "foreign_addr");
    wr(12'h320, 32'hFFFF_FFFF);
    expect_rd(12'h320, 32'h0000_1FFD, 1'b1, "mcountinhibit_mask");
    wr(12'h323, 32'hFFFF_FFFF);
    expect_rd(12'h323, 32'h0000_FFFF, 1'b1, "mhpmevent3_mask");
    wr(12'hB81, 32'd5);
    expect_rd(12'hB81, 32'h0, 1'b1, "time_hi_write_ignored");
    event_v = '1;
    instr_ret = 1'b1;
    repeat (3) tick();
    event_v = '0;
    instr_ret = 1'b0;
    expect_rd(12'hB03, 32'd8, 1'b1, "hpm3_all_inhibited");
    expect_rd(12'hB02, 32'd8, 1'b1, "minstret_all_inhibited");

    // Asynchronous reset mid-cycle
    tick();
    #1;
    rst = 1'b1;
    expect_rd(12'hB00, 32'h0, 1'b1, "rdata_in_reset");
    check("ovf_in_reset", 64'(ovf), 64'd0);
    tick();
    rst = 1'b0;
    bus.csr_addr_i = 12'hB00;
    repeat (2) tick();
    expect_rd(12'hB00, 32'd2, 1'b1, "mcycle_after_rereset");
    expect_rd(12'h320, 32'h0, 1'b1, "inhibit_after_rereset");
    expect_rd(12'h323, 32'h0, 1'b1, "mhpmevent3_after_rereset");
    tick();
    expect_rd(12'hB03, 32'h0, 1'b1, "hpm3_after_rereset");
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
